// File: rtl/coef_stream_loader_pkg.sv
// Shared NTT package: loader FSM states, default geometry and the helper
// that locates a bank's slice inside the packed memory row buses.
package ntt_pkg;

  localparam int D_WIDTH_DEF = 17;
  localparam int BN_DEF      = 16;
  localparam int MA_DEF      = 64;

  typedef enum logic [2:0] {
    IDLE,
    LD_COLLECT,
    LD_WRITE,
    DP_READ,
    DP_WAIT,
    DP_STREAM
  } loader_state_e;

  // LSB position of bank b in a packed row of w-bit coefficients
  function automatic int bank_lsb(input int b, input int w);
    return b * w;
  endfunction

endpackage

// File: rtl/coef_stream_loader_if.sv
// Stream and memory-port bundle around coef_stream_loader.
// master = loader side, slave = host/memory side.
interface coef_stream_loader_if #(
  parameter int D_WIDTH = 17,
  parameter int BN      = 16,
  parameter int ADDR_W  = 6
);
  logic                    s_valid;
  logic                    s_ready;
  logic [D_WIDTH-1:0]      s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [D_WIDTH-1:0]      m_data;
  logic [BN-1:0]           mem_we;
  logic                    mem_re;
  logic [ADDR_W-1:0]       mem_addr;
  logic [BN*D_WIDTH-1:0]   mem_wdata;
  logic [BN*D_WIDTH-1:0]   mem_rdata;

  modport master (
    input  s_valid, s_data, m_ready, mem_rdata,
    output s_ready, m_valid, m_data, mem_we, mem_re, mem_addr, mem_wdata
  );

  modport slave (
    output s_valid, s_data, m_ready, mem_rdata,
    input  s_ready, m_valid, m_data, mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/coef_stream_loader_row_buffer.sv
// coef_row_buffer: one memory row of coefficients held in registers.
// Filled slot by slot from the input stream or in one shot from mem_rdata;
// drained slot by slot to the output stream or in one shot to mem_wdata.
module coef_row_buffer
  import ntt_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int BN      = BN_DEF,
  parameter int BW      = $clog2(BN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [BW-1:0]         i_wr_idx,
  input  logic [D_WIDTH-1:0]    i_wr_data,
  input  logic                  i_ld_en,
  input  logic [BN*D_WIDTH-1:0] i_ld_row,
  input  logic [BW-1:0]         i_rd_idx,
  output logic [D_WIDTH-1:0]    o_rd_data,
  output logic [BN*D_WIDTH-1:0] o_row
);

  logic [BN-1:0][D_WIDTH-1:0] r_mem;

  // Row load wins over slot write; the FSM never asserts both together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else if (i_ld_en) begin
      for (int b = 0; b < BN; b++)
        r_mem[b] <= i_ld_row[bank_lsb(b, D_WIDTH) +: D_WIDTH];
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_row     = r_mem;

endmodule

// File: rtl/coef_stream_loader.sv
// coef_stream_loader: streams coefficients in natural order into BN banks x
// MA rows (coef n = k*BN + b -> bank b, row k) and dumps them back out.
// Optional build macro COEF_LOADER_RANGE_CHECK_EN adds the sticky
// err_range check of accepted s_data against modulus.
module coef_stream_loader
  import ntt_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int BN      = BN_DEF,
  parameter int MA      = MA_DEF,
  parameter int ADDR_W  = (MA > 1) ? $clog2(MA) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_load,
  input  logic                 start_dump,
  input  logic [D_WIDTH-1:0]   modulus,
  coef_stream_loader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_range
);

  localparam int                BW     = $clog2(BN);
  localparam logic [BW-1:0]     B_LAST = BW'(BN - 1);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MA - 1);

  loader_state_e       r_state, w_state_nxt;
  logic [BW-1:0]       r_b, w_b_nxt;
  logic [ADDR_W-1:0]   r_k, w_k_nxt;
  logic                r_done, w_done_nxt;
  logic                w_buf_wr, w_buf_ld;
  logic [D_WIDTH-1:0]  w_rd_data;
  logic [BN*D_WIDTH-1:0] w_row;

  // State and counter registers; reset abandons any partial row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_b     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_b     <= w_b_nxt;
      r_k     <= w_k_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, counter and row-buffer control decode
  always_comb begin
    w_state_nxt = r_state;
    w_b_nxt     = r_b;
    w_k_nxt     = r_k;
    w_done_nxt  = 1'b0;
    w_buf_wr    = 1'b0;
    w_buf_ld    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_load || start_dump) begin
          w_state_nxt = start_load ? LD_COLLECT : DP_READ;
          w_b_nxt     = '0;
          w_k_nxt     = '0;
        end
      end
      LD_COLLECT: begin
        if (bus.s_valid) begin
          w_buf_wr = 1'b1;
          w_b_nxt  = r_b + 1'b1;
          if (r_b == B_LAST) w_state_nxt = LD_WRITE;
        end
      end
      LD_WRITE: begin
        w_b_nxt = '0;
        if (r_k == K_LAST) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_k_nxt     = r_k + 1'b1;
          w_state_nxt = LD_COLLECT;
        end
      end
      DP_READ: w_state_nxt = DP_WAIT;
      DP_WAIT: begin
        w_buf_ld    = 1'b1;
        w_b_nxt     = '0;
        w_state_nxt = DP_STREAM;
      end
      DP_STREAM: begin
        if (bus.m_ready) begin
          w_b_nxt = r_b + 1'b1;
          if (r_b == B_LAST) begin
            if (r_k == K_LAST) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_k_nxt     = r_k + 1'b1;
              w_state_nxt = DP_READ;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  coef_row_buffer #(.D_WIDTH(D_WIDTH), .BN(BN), .BW(BW)) u_row (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_buf_wr),
    .i_wr_idx  (r_b),
    .i_wr_data (bus.s_data),
    .i_ld_en   (w_buf_ld),
    .i_ld_row  (bus.mem_rdata),
    .i_rd_idx  (r_b),
    .o_rd_data (w_rd_data),
    .o_row     (w_row)
  );

  // Every output comes from state or registers, never from s_valid/m_ready
  assign bus.s_ready   = (r_state == LD_COLLECT);
  assign bus.m_valid   = (r_state == DP_STREAM);
  assign bus.m_data    = w_rd_data;
  assign bus.mem_we    = {BN{r_state == LD_WRITE}};
  assign bus.mem_re    = (r_state == DP_READ);
  assign bus.mem_addr  = r_k;
  assign bus.mem_wdata = w_row;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;

`ifdef COEF_LOADER_RANGE_CHECK_EN
  logic r_err;

  // Sticky out-of-range flag; a new load clears it, the data is still stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (r_state == IDLE && start_load)
      r_err <= 1'b0;
    else if (r_state == LD_COLLECT && bus.s_valid && bus.s_data >= modulus)
      r_err <= 1'b1;
  end

  assign err_range = r_err;
`else
  logic w_unused_modulus;
  assign w_unused_modulus = ^modulus;
  assign err_range        = 1'b0;
`endif

endmodule

// File: tb/tb_coef_stream_loader.sv
// Scoreboard bench for coef_stream_loader (BN=16, MA=4, modulus 65537).
module tb_coef_stream_loader;
  import ntt_pkg::*;

  localparam int DW = 17;
  localparam int NB = 16;
  localparam int NM = 4;
  localparam int AW = 2;
  localparam logic [DW-1:0] MOD = 17'd65537;
`ifdef COEF_LOADER_RANGE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start_load = 1'b0, start_dump = 1'b0;
  logic [DW-1:0] modulus = MOD;
  logic busy, done, err_range;

  coef_stream_loader_if #(.D_WIDTH(DW), .BN(NB), .ADDR_W(AW)) bus();

  coef_stream_loader #(.D_WIDTH(DW), .BN(NB), .MA(NM), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_dump(start_dump),
    .modulus(modulus), .bus(bus), .busy(busy), .done(done), .err_range(err_range)
  );

  always #5 clk = ~clk;

  // Memory model: 1-cycle read latency, clear fills with a sentinel
  logic [DW-1:0] mem_model [NB][NM];
  logic          mem_clr = 1'b0;
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_clr)
        for (int k = 0; k < NM; k++) mem_model[b][k] <= '1;
      if (bus.mem_we[b]) mem_model[b][bus.mem_addr] <= bus.mem_wdata[b*DW +: DW];
      if (bus.mem_re) bus.mem_rdata[b*DW +: DW] <= mem_model[b][bus.mem_addr];
    end
  end

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] ld_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] coef_val(input int base, input int idx, input int bad);
    return (idx == bad) ? MOD : DW'(base + idx);
  endfunction

  task automatic clear_mem();
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
  endtask

  task automatic do_load(input int base, input bit toggle, input int bad_idx, input bit chk_lat);
    int idx = 0, cyc = 0, wcnt = 0;
    bit hs, err_pending;
    ld_q.delete();
    clear_mem();
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    check("ld_busy_rise", busy, 1);
    while (!done && cyc < 3000) begin
      bus.s_valid = (idx < NB*NM) && (!toggle || (cyc % 2) == 0);
      bus.s_data  = (idx < NB*NM) ? coef_val(base, idx, bad_idx) : '0;
      hs = bus.s_ready && bus.s_valid;
      err_pending = hs && (idx == bad_idx);
      if (hs) begin
        ld_q.push_back(bus.s_data);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (|bus.mem_we) begin
        wcnt++;
        check("ld_we_mask", bus.mem_we, 16'hFFFF);
      end
      if (err_pending) check("err_next_cycle", err_range, EXP_ERR);
    end
    bus.s_valid = 1'b0;
    check("ld_done", done, 1);
    check("ld_busy_fall", busy, 0);
    check("ld_accepted", idx, NB*NM);
    check("ld_writes", wcnt, NM);
    if (chk_lat) check("ld_done_lat", cyc, NM*(NB+1));
    if (bad_idx >= 0) check("err_at_done", err_range, EXP_ERR);
    else check("err_clear", err_range, 0);
    @(posedge clk); #1;
    check("ld_done_pulse", done, 0);
    for (int k = 0; k < NM; k++)
      for (int b = 0; b < NB; b++)
        check($sformatf("mem_b%0d_k%0d", b, k), mem_model[b][k], coef_val(base, k*NB + b, bad_idx));
  endtask

  task automatic do_dump(input bit rnd);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] held;
    int cyc = 0, hs = 0, rcnt = 0, hs_cyc = -10;
    bit stall;
    exp_q = ld_q;
    start_dump = 1'b1;
    @(posedge clk); #1;
    start_dump = 1'b0;
    check("dp_busy_rise", busy, 1);
    while (!done && cyc < 3000) begin
      if (bus.mem_re) rcnt++;
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = bus.m_valid && !bus.m_ready;
      held  = bus.m_data;
      if (bus.m_valid && bus.m_ready) begin
        hs++;
        hs_cyc = cyc;
        if (exp_q.size() > 0) check("dp_data", bus.m_data, exp_q.pop_front());
        else check("dp_surplus", hs, NB*NM);
      end
      @(posedge clk); #1;
      cyc++;
      if (stall) begin
        check("dp_hold_valid", bus.m_valid, 1);
        check("dp_hold_data", bus.m_data, held);
      end
    end
    bus.m_ready = 1'b0;
    check("dp_done", done, 1);
    check("dp_busy_fall", busy, 0);
    check("dp_handshakes", hs, NB*NM);
    check("dp_reads", rcnt, NM);
    check("dp_done_lat", cyc, hs_cyc + 1);
    check("dp_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check("dp_done_pulse", done, 0);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_s_ready"}, bus.s_ready, 0);
    check({pfx, "_m_valid"}, bus.m_valid, 0);
    check({pfx, "_mem_we"}, bus.mem_we, 0);
    check({pfx, "_mem_re"}, bus.mem_re, 0);
    check({pfx, "_mem_addr"}, bus.mem_addr, 0);
    check({pfx, "_mem_wdata"}, |bus.mem_wdata, 0);
    check({pfx, "_m_data"}, bus.m_data, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_err"}, err_range, 0);
  endtask

  initial begin
    int hs, cyc, wcnt;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_load(0, 1'b0, 5, 1'b1);    // 65537 at index 5
    do_load(0, 1'b0, -1, 1'b1);   // continuous, also clears err_range
    do_dump(1'b0);
    do_load(0, 1'b1, -1, 1'b0);   // s_valid toggling
    do_dump(1'b0);
    do_dump(1'b1);                // random backpressure

    // Reset in the middle of row 1
    clear_mem();
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    hs = 0; cyc = 0; wcnt = 0;
    while (hs < 20 && cyc < 200) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(hs);
      if (bus.s_ready) hs++;
      @(posedge clk); #1;
      cyc++;
      if (|bus.mem_we) wcnt++;
    end
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (3) begin
      @(posedge clk); #1;
      if (|bus.mem_we) wcnt++;
    end
    check("midrst_writes", wcnt, 1);
    check("midrst_row1_untouched", mem_model[0][1], 17'h1FFFF);
    check("midrst_row0_b3", mem_model[3][0], 3);
    rst = 1'b0;
    @(posedge clk); #1;

    do_load(100, 1'b0, -1, 1'b1);
    do_dump(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/coef_stream_loader.md
# coef_stream_loader

Streaming load/dump engine for the banked NTT coefficient memory. Accepts polynomial coefficients in natural index order on a valid/ready stream and writes them into `BN` banks × `MA` rows, with coefficient n = k·BN + b at bank b, row k. It also reads the banks back out in the same order on an output stream. It sits between the host/testbench stream and the memory write/read ports in front of `memory_top`. This replaces hierarchical backdoor preload and dump with real bus cycles.

## Interface
Parameters:
- `D_WIDTH`, 17, coefficient width (fits modulus 65537)
- `BN`, 16, bank count (≥2, power of 2)
- `MA`, 64, rows per bank (≥1); polynomial degree = BN·MA
- `ADDR_W`, $clog2(MA) (min 1), row address width

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `start_load` in 1: begin load (sampled in IDLE only)
- `start_dump` in 1: begin dump (sampled in IDLE only)
- `modulus` in D_WIDTH: range-check bound
- `s_valid` / `s_ready` in/out 1: input stream handshake
- `s_data` in D_WIDTH: input coefficient
- `m_valid` / `m_ready` out/in 1: output stream handshake
- `m_data` out D_WIDTH: output coefficient
- `mem_we` out BN: per-bank write enable
- `mem_re` out 1: row read enable
- `mem_addr` out ADDR_W: shared row address
- `mem_wdata` out BN·D_WIDTH: bank b in bits [b·D_WIDTH +: D_WIDTH]
- `mem_rdata` in BN·D_WIDTH: same packing; valid 1 cycle after `mem_re`
- `busy` out 1: high whenever state ≠ IDLE
- `done` out 1: 1-cycle pulse at operation end
- `err_range` out 1: sticky out-of-range flag

## Operation
- FSM states: IDLE, LD_COLLECT, LD_WRITE, DP_READ, DP_WAIT, DP_STREAM.
- IDLE: `start_load` → LD_COLLECT. `start_dump` (without `start_load`) → DP_READ. Both high in the same cycle → load wins. Each start clears the bank counter `b` and row counter `k`. `start_load` also clears `err_range`.
- LD_COLLECT: `s_ready`=1. Each handshake stores `s_data` into row buffer slot `b` and increments `b`. At the handshake with b=BN−1 → LD_WRITE.
- LD_WRITE: `s_ready`=0, `mem_we`=all ones, `mem_addr`=k, `mem_wdata`=row buffer. If k=MA−1 → IDLE with `done`; otherwise k++, b=0, → LD_COLLECT.
- DP_READ: `mem_re`=1, `mem_addr`=k, → DP_WAIT.
- DP_WAIT: capture `mem_rdata` into the row buffer, b=0, → DP_STREAM.
- DP_STREAM: `m_valid`=1, `m_data`=buffer[b]. On handshake, b++. Handshake at b=BN−1: if k=MA−1 → IDLE with `done`, else k++ → DP_READ.
- `m_data` and `m_valid` hold stable while `m_ready`=0. Data is passed unmodified: no reduction, no wrap.
- Start pulses while busy are ignored.
- `rst` mid-operation: immediate return to IDLE with all counters cleared. No partial row is written. The row buffer contents are discarded.

## Timing
- Reset values: `s_ready`, `m_valid`, `mem_we`, `mem_re`, `busy`, `done`, `err_range` = 0. `mem_addr`, `mem_wdata`, `m_data` = 0.
- All outputs are registered or decoded from state only. No combinational path from `s_valid` or `m_ready` to any output.
- Load with continuous `s_valid`: BN+1 cycles per row, MA·(BN+1) cycles total. `done` rises 1 cycle after the last LD_WRITE cycle.
- Dump with continuous `m_ready`: BN+2 cycles per row. First `m_valid` appears 3 cycles after the `start_dump` edge.
- `busy` rises the cycle after start and falls in the same cycle `done` rises.

## Configuration
- `COEF_LOADER_RANGE_CHECK_EN` defined: each accepted `s_data` ≥ `modulus` sets `err_range` on the next edge. The flag stays set until the next `start_load` or `rst`. The coefficient is still written unchanged.
- Macro undefined: no comparator is built and `err_range` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `ntt_pkg`: state enum `loader_state_e`, default `D_WIDTH`/`BN`/`MA` constants, and the bank slice helper function for packed `mem_wdata`/`mem_rdata`.
- One sub-module, `coef_row_buffer`: BN×D_WIDTH register file with indexed write, parallel load from `mem_rdata`, indexed read, and parallel read to `mem_wdata`.

## Test plan
All scenarios use BN=16, MA=4, modulus 65537.
- Load 0..63 with `s_valid` continuous → bank b row k = 16k+b. `mem_we`=16'hFFFF for exactly 4 cycles. `done` arrives 68 cycles after start.
- Load 0..63 with `s_valid` toggling every cycle → identical memory contents. Exactly 4 write cycles.
- Dump after the load with `m_ready`=1 → `m_data` = 0,1,…,63 in order. `done` follows the 64th handshake. Exactly 4 `mem_re` pulses.
- Dump with `m_ready` random (50%) → `m_data` stable during stalls. Sequence still 0..63.
- Assert `rst` after 20 accepted coefficients → all outputs 0 at once and no write for row 1. A new load of 100..163 then lands correctly.
- With `COEF_LOADER_RANGE_CHECK_EN`, send 65537 at index 5 → `err_range`=1 from the next cycle and held through `done`. The value is written to bank 5 row 0. Without the macro, `err_range` stays 0.
